// File: rtl/button_scanner_if.sv
// Button scanner signal bundle: raw pins in, debounced levels and single-cycle events out.
// The release event is carried as release_evt because "release" is a reserved word.
interface button_scanner_if #(
   parameter int N_BTN = 5,
   parameter int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
);
   logic [N_BTN-1:0] b_in;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] release_evt;
   logic [N_BTN-1:0] hold;
   logic             any_press;
   logic [IDX_W-1:0] evt_idx;

   modport master (
      input  b_in,
      output level,
      output press,
      output release_evt,
      output hold,
      output any_press,
      output evt_idx
   );

   modport slave (
      output b_in,
      input  level,
      input  press,
      input  release_evt,
      input  hold,
      input  any_press,
      input  evt_idx
   );
endinterface

// File: rtl/button_scanner.sv
// N-channel push-button front end: synchroniser, debounce, press/release/hold pulses.
// Optional macro BTN_AUTOREPEAT_EN: hold re-pulses every REPEAT_CYCLES while the button stays pressed.
//
// Hold tracker, one per channel:
//   state  | meaning
//   H_IDLE | button released, nothing counting
//   H_WAIT | pressed, counting towards the first hold pulse
//   H_DONE | first hold pulse sent, counter saturated until release
//   H_RPT  | auto-repeat: counting towards the next repeat pulse
module button_scanner #(
   parameter int N_BTN           = 5,
   parameter int ACTIVE_HIGH     = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input logic               clk,
   input logic               rst,
   button_scanner_if.master  bus
);

   localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_SPAN = (REPEAT_CYCLES > HOLD_CYCLES) ? REPEAT_CYCLES : HOLD_CYCLES;
   localparam int HOLD_W = $clog2(HOLD_SPAN + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic              IDLE_PIN  = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

   localparam logic [1:0] H_IDLE = 2'd0;
   localparam logic [1:0] H_WAIT = 2'd1;
   localparam logic [1:0] H_DONE = 2'd2;
   localparam logic [1:0] H_RPT  = 2'd3;

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] s;
   logic [N_BTN-1:0] level_q;
   logic [N_BTN-1:0] toggle;
   logic [N_BTN-1:0] press_next;
   logic [N_BTN-1:0] press_q;
   logic [N_BTN-1:0] release_q;
   logic [N_BTN-1:0] hold_q;
   logic             any_press_q;
   logic [IDX_W-1:0] evt_idx_q;
   logic [IDX_W-1:0] idx_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= {N_BTN{IDLE_PIN}};
         sync2 <= {N_BTN{IDLE_PIN}};
      end else begin
         sync1 <= bus.b_in;
         sync2 <= sync1;
      end
   end

   assign s = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [DB_W-1:0]   db_cnt;
      logic              lvl;
      logic              tgl;
      logic              press_r;
      logic              release_r;
      logic [1:0]        h_state;
      logic [HOLD_W-1:0] h_cnt;
      logic              hold_r;

      assign tgl = (s[i] != lvl) && (db_cnt == DB_LAST);

      always_ff @(posedge clk) begin
         if (rst) begin
            db_cnt    <= '0;
            lvl       <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            press_r   <= tgl & ~lvl;
            release_r <= tgl & lvl;
            if (tgl) begin
               lvl    <= ~lvl;
               db_cnt <= '0;
            end else if (s[i] == lvl) begin
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      // The toggle edge both starts the count (press) and cancels any pending pulse (release).
      always_ff @(posedge clk) begin
         if (rst) begin
            h_state <= H_IDLE;
            h_cnt   <= '0;
            hold_r  <= 1'b0;
         end else begin
            hold_r <= 1'b0;
            if (tgl) begin
               h_cnt   <= '0;
               h_state <= lvl ? H_IDLE : H_WAIT;
            end else begin
               case (h_state)
                  H_WAIT: begin
                     if (h_cnt == HOLD_LAST) begin
                        hold_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        h_cnt   <= '0;
                        h_state <= H_RPT;
`else
                        h_cnt   <= HOLD_W'(HOLD_CYCLES);
                        h_state <= H_DONE;
`endif
                     end else begin
                        h_cnt <= h_cnt + 1'b1;
                     end
                  end
`ifdef BTN_AUTOREPEAT_EN
                  H_RPT: begin
                     if (h_cnt == HOLD_W'(REPEAT_CYCLES - 1)) begin
                        hold_r <= 1'b1;
                        h_cnt  <= '0;
                     end else begin
                        h_cnt <= h_cnt + 1'b1;
                     end
                  end
`endif
                  default: begin
                     h_cnt <= h_cnt;
                  end
               endcase
            end
         end
      end

      assign level_q[i]    = lvl;
      assign toggle[i]     = tgl;
      assign press_next[i] = tgl & ~lvl;
      assign press_q[i]    = press_r;
      assign release_q[i]  = release_r;
      assign hold_q[i]     = hold_r;
   end

   // Lowest channel wins when several press together; holds the old index otherwise.
   always_comb begin
      idx_next = evt_idx_q;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press_next[i]) idx_next = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         any_press_q <= 1'b0;
         evt_idx_q   <= '0;
      end else begin
         any_press_q <= |press_next;
         evt_idx_q   <= idx_next;
      end
   end

   assign bus.level       = level_q;
   assign bus.press       = press_q;
   assign bus.release_evt = release_q;
   assign bus.hold        = hold_q;
   assign bus.any_press   = any_press_q;
   assign bus.evt_idx     = evt_idx_q;

endmodule

// File: tb/tb_button_scanner.sv
// Directed bench for button_scanner with DEBOUNCE=4, HOLD=20, REPEAT=8.
// Expected hold timing follows BTN_AUTOREPEAT_EN when it is defined for the build.
module tb_button_scanner;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   button_scanner_if #(.N_BTN(5)) bus ();

   button_scanner #(
      .N_BTN(5),
      .ACTIVE_HIGH(1),
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(20),
      .REPEAT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] acc_p;
   logic [4:0] acc_r;
   logic [4:0] acc_h;
   logic [4:0] acc_l;
   logic       acc_any;

   task automatic run_acc(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         acc_p   = acc_p | bus.press;
         acc_r   = acc_r | bus.release_evt;
         acc_h   = acc_h | bus.hold;
         acc_l   = acc_l | bus.level;
         acc_any = acc_any | bus.any_press;
      end
   endtask

   task automatic clr_acc();
      acc_p = '0; acc_r = '0; acc_h = '0; acc_l = '0; acc_any = 1'b0;
   endtask

   int press_at;
   int rel_at;
   int hold_n;
   int hold_k[4];
   int hold_after_rel;

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.b_in = 5'b00000;

      // reset then idle
      step(); step(); step();
      check("rst_level", 32'(bus.level), 0);
      check("rst_press", 32'(bus.press), 0);
      check("rst_release", 32'(bus.release_evt), 0);
      check("rst_hold", 32'(bus.hold), 0);
      check("rst_any", 32'(bus.any_press), 0);
      check("rst_idx", 32'(bus.evt_idx), 0);
      rst = 1'b0;
      clr_acc();
      run_acc(50);
      check("idle_pulses", 32'({acc_p, acc_r, acc_h, acc_l, 4'b0, acc_any}), 0);

      // clean press / release on channel 2
      bus.b_in = 5'b00100;
      clr_acc();
      run_acc(5);
      check("clean_early", 32'({acc_l, acc_p}), 0);
      step();
      check("clean_level", 32'(bus.level), 32'h04);
      check("clean_press", 32'(bus.press), 32'h04);
      check("clean_any", 32'(bus.any_press), 1);
      check("clean_idx", 32'(bus.evt_idx), 2);
      step();
      check("clean_press_1cyc", 32'(bus.press), 0);
      check("clean_any_1cyc", 32'(bus.any_press), 0);
      bus.b_in = 5'b00000;
      clr_acc();
      run_acc(5);
      check("rel_early", 32'(acc_r), 0);
      check("rel_level_held", 32'(bus.level), 32'h04);
      step();
      check("rel_pulse", 32'(bus.release_evt), 32'h04);
      check("rel_level", 32'(bus.level), 0);
      step();
      check("rel_1cyc", 32'(bus.release_evt), 0);
      clr_acc();
      run_acc(25);
      check("short_no_hold", 32'(acc_h), 0);

      // bounce on channel 0: mismatch runs never reach 4
      clr_acc();
      bus.b_in = 5'b00001; run_acc(1);
      bus.b_in = 5'b00000; run_acc(1);
      bus.b_in = 5'b00001; run_acc(1);
      bus.b_in = 5'b00001; run_acc(1);
      bus.b_in = 5'b00000;
      run_acc(20);
      check("bounce_none", 32'({acc_l, acc_p, acc_r}), 0);

      // simultaneous press on channels 1 and 3
      bus.b_in = 5'b01010;
      run_acc(5);
      step();
      check("sim_press", 32'(bus.press), 32'h0A);
      check("sim_idx", 32'(bus.evt_idx), 1);
      check("sim_any", 32'(bus.any_press), 1);
      bus.b_in = 5'b00000;
      clr_acc();
      run_acc(8);
      check("sim_release", 32'(acc_r), 32'h0A);
      check("idx_holds", 32'(bus.evt_idx), 1);
      check("sim_no_press", 32'({acc_p, 4'b0, acc_any}), 0);

      // long press on channel 4, pin dropped after 40 cycles
      press_at = -1; rel_at = -1; hold_n = 0; hold_after_rel = 0;
      for (int j = 0; j < 4; j++) hold_k[j] = -1;
      bus.b_in = 5'b10000;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (bus.press[4] && press_at < 0) press_at = k;
         if (bus.release_evt[4] && rel_at < 0) rel_at = k;
         if (bus.hold[4]) begin
            if (hold_n < 4) hold_k[hold_n] = k;
            hold_n++;
            if (rel_at >= 0) hold_after_rel++;
         end
         if (k == 40) bus.b_in = 5'b00000;
      end
      check("long_press_at", press_at, 6);
      check("long_hold_first", hold_k[0], 26);
`ifdef BTN_AUTOREPEAT_EN
      check("long_hold_count", hold_n, 3);
      check("long_hold_rpt1", hold_k[1], 34);
      check("long_hold_rpt2", hold_k[2], 42);
`else
      check("long_hold_count", hold_n, 1);
`endif
      check("long_release_at", rel_at, 46);
      check("long_no_hold_after_rel", hold_after_rel, 0);

      // reset while channel 0 is pressed
      bus.b_in = 5'b00001;
      run_acc(5);
      step();
      check("mid_level_before", 32'(bus.level), 32'h01);
      rst = 1'b1;
      step();
      check("mid_rst_level", 32'(bus.level), 0);
      check("mid_rst_release", 32'(bus.release_evt), 0);
      step();
      rst = 1'b0;
      clr_acc();
      run_acc(5);
      check("mid_no_early_press", 32'({acc_p, acc_r}), 0);
      step();
      check("mid_repress", 32'(bus.press), 32'h01);
      check("mid_relevel", 32'(bus.level), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_scanner.md
Name: button_scanner

Overview:
- Parametrised successor to the fixed five-button debounce front end: N_BTN independent channels, configurable input polarity, debounce length and long-press timing.
- Per channel: 2-flop synchroniser, debounce counter, stable level, one-cycle press/release pulses, long-press (hold) detection.
- Sits between board push-button pins and control FSMs (PC step/run, shifter mode select), which consume single-cycle events instead of raw levels.

Parameters:
- N_BTN, 5, number of button channels (bit order stays [Right, Down, Left, Up, Center] for default board use).
- ACTIVE_HIGH, 1, 1 = pressed pin reads 1; 0 = pressed pin reads 0 (inverted after synchroniser).
- DEBOUNCE_CYCLES, 500000, consecutive samples of a new value before the stable level changes; must be >= 1.
- HOLD_CYCLES, 50000000, cycles pressed (after press pulse) before the hold pulse fires; must be >= 1.
- REPEAT_CYCLES, 10000000, auto-repeat period; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- b_in  input  N_BTN  raw asynchronous button pins.
- level  output  N_BTN  debounced pressed state, 1 = pressed (polarity normalised).
- press  output  N_BTN  one-cycle pulse on debounced 0->1.
- release  output  N_BTN  one-cycle pulse on debounced 1->0.
- hold  output  N_BTN  one-cycle pulse when pressed for HOLD_CYCLES (plus repeats if enabled).
- any_press  output  1  OR of press.
- evt_idx  output  $clog2(N_BTN) (min 1)  index of lowest-numbered channel with press this cycle; valid when any_press=1, holds last value otherwise.

Behaviour:
- Clock/reset: single clock `clk`; reset `rst` is synchronous and active-high. Sampled on rising edge of clk, it clears the whole block.
- Reset values: level, press, release, hold, any_press, evt_idx all 0. Sync flops are loaded with the idle pin value (0 if ACTIVE_HIGH, 1 otherwise). Debounce and hold counters are 0.
- Synchroniser: two flops per channel, then polarity normalisation to s[i] (1 = pressed).
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES) (min 1):
  - s[i] == level[i]: counter cleared.
  - s[i] != level[i] and counter == DEBOUNCE_CYCLES-1: level[i] toggles, counter cleared.
  - otherwise: counter increments.
- Latency: pin steady at its new value from edge E0 onward -> level, press/release update at edge E0+DEBOUNCE_CYCLES+1 (two sync stages plus DEBOUNCE_CYCLES samples).
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES produces no level change and no pulse. The counter restarts from 0 on the first matching sample.
- press[i]/release[i]: registered, high for exactly the one cycle following the level toggle edge. Never both high on one channel in the same cycle.
- Hold, per channel: hold counter clears on press and on release, and increments while level[i] = 1. The cycle it reaches HOLD_CYCLES, hold[i] pulses once and the counter saturates; no further hold pulse until release and a fresh press. A release before HOLD_CYCLES gives no hold pulse.
- Channels are fully independent; simultaneous presses on several channels pulse together.
- any_press and evt_idx are registered in the same cycle as press. evt_idx selects the lowest index when several channels press together.
- Reset mid-operation: pending counts are discarded and no release pulse is emitted. A button still held after reset reports press again after the full debounce latency.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: after the first hold pulse, the counter reloads to 0 and hold[i] re-pulses every REPEAT_CYCLES cycles while level[i] stays 1. Release stops repeats immediately; no pulse in the release cycle.
- Undefined: a single hold pulse per press; REPEAT_CYCLES is ignored and no repeat logic is synthesised.

Test Plan:
All scenarios use N_BTN=5, ACTIVE_HIGH=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Reset then idle: rst high 3 cycles, b_in=0 -> all outputs 0, and no pulses for 50 cycles after rst falls.
- Clean press: b_in[2] 0->1 steady from edge E0 -> level[2]=1 and press[2]=1 at E0+5 only, any_press=1, evt_idx=2. Releasing later gives release[2] one cycle at +5.
- Bounce: b_in[0] toggles 1,0,1,1,0 across successive cycles, then stays 0 -> no level change, press or release at any time.
- Simultaneous: b_in[1] and b_in[3] rise together -> press=5'b01010 for one cycle, evt_idx=1.
- Long press: b_in[4] held 40 cycles -> hold[4] pulses once, 20 cycles after press[4]. With BTN_AUTOREPEAT_EN, further hold pulses follow at +8 and +16 cycles after the first, then release[4] with no further hold.
- Reset mid-press: assert rst while level[0]=1 -> level[0]=0 with no release pulse. With b_in[0] still 1, press[0] reappears 5 cycles after rst deasserts.
